a26_cart_loader: RTL and testbench

A26_CART_LOADER -- requirements
Module: a26_cart_loader

---
 rtl/a26_cart_pkg.sv | 17 +
 rtl/a26_pow2_ceil.sv | 17 +
 rtl/a26_cart_loader.sv | 140 ++++++++++++++
 tb/tb_a26_cart_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a26_cart_pkg.sv
// Shared definitions for the Atari 2600 cartridge loader: loader states and
// cartridge RAM geometry.
package a26_cart_pkg;

    localparam int unsigned CART_AW    = 13;
    localparam int unsigned CART_BYTES = 8192;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MIR_RD,
        MIR_LAT,
        MIR_WR,
        DONE
    } cart_state_t;

endpackage

// File: rtl/a26_pow2_ceil.sv
// Smallest power of two greater than or equal to value.
// A zero input gives 1. An input above 8192 gives 0.
module a26_pow2_ceil (
    input  logic [13:0] value,
    output logic [13:0] result
);

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            if (result == '0 && (14'd1 << i) >= value) begin
                result = 14'd1 << i;
            end
        end
    end

endmodule

// File: rtl/a26_cart_loader.sv
// Copies an HPS cartridge download into cartridge RAM.
// Images smaller than 8K are then mirrored up through the whole 8K window.
module a26_cart_loader
    import a26_cart_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX = 8'd1,
    parameter int unsigned MIN_IMAGE = 256
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic [31:0] cart_size,
    output logic        load_done,
    output logic        core_hold
);

    cart_state_t state_q, state_d;
    logic [31:0] cart_size_q;
    logic [13:0] dest_q;
    logic [12:0] period_q;
    logic        wr_pend_q;
    logic [12:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    logic        rom_dl;
    logic        size_fits;
    logic [13:0] span;
    logic [13:0] period_d;
    logic [25:0] wr_end;
    logic [12:0] mask;

    assign rom_dl    = ioctl_download && (ioctl_index == ROM_INDEX);
    assign size_fits = (cart_size_q != '0) && (cart_size_q < CART_BYTES);
    assign span      = (cart_size_q[13:0] > 14'(MIN_IMAGE)) ? cart_size_q[13:0] : 14'(MIN_IMAGE);
    assign wr_end    = {1'b0, ioctl_addr} + 26'd1;
    assign mask      = period_q - 13'd1;

    a26_pow2_ceil u_pow2_ceil (
        .value  (span),
        .result (period_d)
    );

    // A write that arrives with the falling download holds LOAD one extra cycle.
    // That keeps its RAM write inside LOAD and puts it into cart_size before the decision.
    always_comb begin
        state_d = state_q;
        if (state_q != LOAD && rom_dl) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (!ioctl_download && !ioctl_wr) begin
                        if (!size_fits || period_d == 14'(CART_BYTES)) state_d = DONE;
                        else                                           state_d = MIR_RD;
                    end
                end
                MIR_RD:  state_d = MIR_LAT;
                MIR_LAT: state_d = MIR_WR;
                MIR_WR:  state_d = (dest_q == 14'(CART_BYTES - 1)) ? DONE : MIR_RD;
                default: state_d = state_q;
            endcase
        end
    end

    // The read address is held through MIR_LAT, so ram_dout is still valid in MIR_WR.
    always_comb begin
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        ioctl_wait = 1'b0;
        case (state_q)
            LOAD: begin
                if (wr_pend_q) begin
                    ram_we   = 1'b1;
                    ram_addr = wr_addr_q;
                    ram_din  = wr_data_q;
                end
            end
            MIR_RD, MIR_LAT: begin
                ioctl_wait = 1'b1;
                ram_addr   = dest_q[12:0] & mask;
            end
            MIR_WR: begin
                ioctl_wait = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = dest_q[12:0];
                ram_din    = ram_dout;
            end
            default: ;
        endcase
    end

    assign load_done = (state_q == DONE);
    assign core_hold = ~load_done;
    assign cart_size = cart_size_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            cart_size_q <= '0;
            dest_q      <= '0;
            period_q    <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= 1'b0;
            if (state_q != LOAD && state_d == LOAD) begin
                cart_size_q <= '0;
            end
            if (state_q == LOAD && ioctl_wr) begin
                if (ioctl_addr[24:CART_AW] == '0) begin
                    wr_pend_q <= 1'b1;
                    wr_addr_q <= ioctl_addr[12:0];
                    wr_data_q <= ioctl_dout;
                end
                if ({6'd0, wr_end} > cart_size_q) begin
                    cart_size_q <= {6'd0, wr_end};
                end
            end
            if (state_q == LOAD && state_d == MIR_RD) begin
                dest_q   <= period_d;
                period_q <= period_d[12:0];
            end else if (state_q == MIR_WR) begin
                dest_q <= dest_q + 14'd1;
            end
        end
    end

endmodule

// File: tb/tb_a26_cart_loader.sv
// Self-checking bench for a26_cart_loader.
// It includes a cartridge RAM model and an image-level reference of the expected RAM contents.
module tb_a26_cart_loader;

    localparam logic [7:0] ROM_IDX = 8'd1;
    localparam int MIN_IMG = 256;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout = '0;
    logic [31:0] cart_size;
    logic        load_done;
    logic        core_hold;

    a26_cart_loader #(.ROM_INDEX(ROM_IDX), .MIN_IMAGE(MIN_IMG)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .ram_dout       (ram_dout),
        .cart_size      (cart_size),
        .load_done      (load_done),
        .core_hold      (core_hold)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] tb_ram [8192];
    logic [7:0] exp_ram [8192];
    logic [7:0] img [16384];
    int we_count = 0;
    int bad_we = 0;
    bit wait_seen = 0;
    int checks = 0;
    int failures = 0;

    // Cartridge RAM: synchronous write, registered read.
    always @(posedge clk_sys) begin
        if (ram_we) begin
            tb_ram[ram_addr] <= ram_din;
            we_count++;
            if (load_done) bad_we++;
        end
        ram_dout <= tb_ram[ram_addr];
        if (ioctl_wait) wait_seen = 1;
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int period_of(input int size);
        int p = MIN_IMG;
        while (p < size) p = p * 2;
        return p;
    endfunction

    task automatic model_load(input int size);
        int lim = (size < 8192) ? size : 8192;
        for (int a = 0; a < lim; a++) exp_ram[a] = img[a];
        if (size > 0 && size < 8192) begin
            int p = period_of(size);
            for (int a = p; a < 8192; a++) exp_ram[a] = exp_ram[a % p];
        end
    endtask

    function automatic int model_writes(input int size);
        int w = (size < 8192) ? size : 8192;
        if (size > 0 && size < 8192 && period_of(size) < 8192) w += 8192 - period_of(size);
        return w;
    endfunction

    task automatic stream(input int size, input bit fall_wr, input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < size; i++) begin
            ioctl_wr = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = img[i];
            if (fall_wr && i == size - 1) ioctl_download = 1'b0;
            @(negedge clk_sys);
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
    endtask

    typedef struct {
        int size;
        bit fall_wr;
        int exp_size;
        int exp_lat;
        bit exp_wait;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int mism;
        int first_bad;
        int we0;
        bit found;

        // latency: negedges from the first cycle with download and write both low to load_done
        vecs[0] = '{2048,  1'b0, 2048,  1 + 3*6144, 1'b1};
        vecs[1] = '{8192,  1'b0, 8192,  1,          1'b0};
        vecs[2] = '{1000,  1'b0, 1000,  1 + 3*7168, 1'b1};
        vecs[3] = '{16384, 1'b0, 16384, 1,          1'b0};
        vecs[4] = '{0,     1'b0, 0,     1,          1'b0};
        vecs[5] = '{6000,  1'b1, 6000,  1,          1'b0};

        for (int a = 0; a < 8192; a++) begin
            tb_ram[a] = 8'h00;
            exp_ram[a] = 8'h00;
        end

        repeat (3) @(negedge clk_sys);
        check("rst_load_done", load_done, 0);
        check("rst_core_hold", core_hold, 1);
        check("rst_cart_size", cart_size, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ioctl_wait", ioctl_wait, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("idle_writes", we_count, 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 16384; i++) begin
                if (v == 0) img[i] = 8'(i);
                else if (i >= 8192) img[i] = 8'(i) ^ 8'hA5;
                else img[i] = 8'($urandom);
            end
            we0 = we_count;
            wait_seen = 0;
            stream(vecs[v].size, vecs[v].fall_wr, ROM_IDX);
            n = 0;
            while (!load_done && n < 30000) begin
                @(negedge clk_sys);
                n++;
            end
            model_load(vecs[v].size);
            $display("vector %0d size=%0d latency=%0d", v, vecs[v].size, n);
            check("done_latency", n, vecs[v].exp_lat);
            check("cart_size", cart_size, vecs[v].exp_size);
            check("wait_seen", wait_seen, vecs[v].exp_wait);
            check("write_count", we_count - we0, model_writes(vecs[v].size));
            mism = 0;
            first_bad = -1;
            for (int a = 0; a < 8192; a++) begin
                if (tb_ram[a] !== exp_ram[a]) begin
                    mism++;
                    if (first_bad < 0) first_bad = a;
                end
            end
            if (first_bad >= 0)
                $display("first bad address %0d: ram=%0h model=%0h", first_bad,
                         tb_ram[first_bad], exp_ram[first_bad]);
            check("ram_image_mismatches", mism, 0);
        end

        // A download to another slot must leave the loaded cartridge alone.
        we0 = we_count;
        wait_seen = 0;
        stream(64, 1'b0, 8'd2);
        repeat (4) @(negedge clk_sys);
        check("idx2_writes", we_count - we0, 0);
        check("idx2_cart_size", cart_size, 6000);
        check("idx2_load_done", load_done, 1);
        check("idx2_wait", wait_seen, 0);

        // A 4K image begins mirroring and is then aborted by a new matching download.
        img[4095] = 8'h5A;
        @(negedge clk_sys);
        ioctl_index = ROM_IDX;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd4095;
        ioctl_dout = img[4095];
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        repeat (30) @(negedge clk_sys);
        check("mirror_busy_wait", ioctl_wait, 1);
        check("mirror_cart_size", cart_size, 4096);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("abort_wait", ioctl_wait, 0);
        check("abort_cart_size", cart_size, 0);
        check("abort_load_done", load_done, 0);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd4095;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;

        // Reset is applied in the middle of mirroring, while the write to dest=5000 is active.
        found = 0;
        for (int c = 0; c < 5000 && !found; c++) begin
            @(negedge clk_sys);
            if (ram_we && ram_addr == 13'd5000 && ioctl_wait) found = 1;
        end
        check("reach_dest_5000", found, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midrst_ram_we", ram_we, 0);
        check("midrst_wait", ioctl_wait, 0);
        check("midrst_cart_size", cart_size, 0);
        check("midrst_core_hold", core_hold, 1);
        check("midrst_ram_addr", ram_addr, 0);
        check("midrst_ram_din", ram_din, 0);
        reset = 1'b0;
        we0 = we_count;
        repeat (5) @(negedge clk_sys);
        check("post_rst_writes", we_count - we0, 0);
        check("post_rst_load_done", load_done, 0);
        check("we_while_done", bad_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
